icache_axi_refill: RTL and testbench
====================================

# icache_axi_refill

Read-refill engine between the I-cache second stage and the AXI4 read channel. Accepts a one-cycle miss request with a line address and issues one AXI4 INCR burst: 8 beats × 32 bit for a cached line, or 1 beat for an uncached fetch. Assembles the returned beats into a 256-bit line, then signals completion with a one-cycle end pulse. The line stays stable for the stage-2 word select and the cache install.

## Interface
- ARID_VAL, default 4'd0: constant driven on arid_o.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_i  in  1  refill request; sampled only in IDLE.
- addr_i  in  32  physical fetch address.
- uncached_i  in  1  1 = single-beat uncached read.
- busy_o  out  1  high in every state except IDLE.
- rend_o  out  1  one-cycle pulse: line_o valid.
- rerr_o  out  1  one-cycle pulse with rend_o when any beat returned rresp != OKAY.
- line_o  out  256  assembled line; word k is bits [32k+31:32k].
- arid_o  out  4  equals ARID_VAL.
- araddr_o  out  32  burst address.
- arlen_o  out  8  7 when cached, 0 when uncached.
- arsize_o  out  3  constant 3'b010.
- arburst_o  out  2  constant 2'b01 (INCR).
- arlock_o, arcache_o, arprot_o  out  1/4/3  constant 0.
- arvalid_o  out  1  address valid.
- arready_i  in  1  address accepted.
- rid_i  in  4  ignored.
- rdata_i  in  32  beat data.
- rresp_i  in  2  beat response.
- rlast_i  in  1  last beat.
- rvalid_i  in  1  beat valid.
- rready_o  out  1  beat accept.

## Operation
- States: IDLE, ADDR, DATA, DONE.
- IDLE, req_i=1:
  - latch the address: cached → {addr_i[31:5],5'b0}; uncached → addr_i[31:2],2'b00.
  - latch uncached_i; clear beat counter cnt (3 bit) and the error flag; zero line_o; go to ADDR.
- ADDR: arvalid_o=1 with stable latched fields. On arvalid_o & arready_i, go to DATA.
- DATA: rready_o=1. On each rvalid_i:
  - write rdata_i into line word cnt;
  - OR (rresp_i != 0) into the error flag;
  - cnt++, saturating at 7; beats after the 8th do not overwrite word 7.
  - On a beat with rlast_i=1, go to DONE.
- DONE: rend_o=1 and rerr_o=error flag for exactly one cycle, then IDLE.
- line_o holds its value from DONE until the next accepted request.
- Uncached fetch: data lands in word 0; words 1–7 read zero.
- req_i in ADDR, DATA or DONE is ignored. No queuing: the requester holds off while busy_o=1.
- Early rlast_i (fewer beats than arlen+1): the transfer ends anyway; unwritten words stay 0.
- rid_i is not checked; a single outstanding burst is guaranteed.
- Reset, at any time including mid-burst:
  - state=IDLE, cnt=0, line_o=0, latched address=0;
  - arvalid_o=0, rready_o=0, rend_o=0, rerr_o=0, busy_o=0.
  - Outstanding beats arriving after reset are dropped (rready_o=0).

## Timing
- Request sampled at edge 0 → arvalid_o high in cycle 1.
- With arready_i held high and back-to-back rvalid_i:
  - AR handshake in cycle 1;
  - rready_o high from cycle 2; beats in cycles 2–9;
  - rend_o in cycle 10; busy_o low and a new request accepted in cycle 11.
- Uncached: same timing, single beat in cycle 2, rend_o in cycle 3.
- AR stalls, and R bubbles (rvalid_i=0), each add one cycle per idle cycle. No timeout.
- arvalid_o, once high, stays high with a constant araddr_o until arready_i (AXI rule).
- All outputs are registered or decoded from state only. There is no combinational path from any AXI input to arvalid_o or rready_o.

## Test plan
- Cached refill:
  - stimulus: addr_i=0x1FC0_0234, zero-wait slave returning 0x11111111…0x88888888;
  - response: araddr_o=0x1FC0_0220, arlen_o=7; rend_o in cycle 10; line_o[31:0]=0x11111111, line_o[255:224]=0x88888888; rerr_o=0.
- Uncached fetch:
  - stimulus: addr_i=0xBFC0_0004, uncached_i=1, data 0xDEADBEEF;
  - response: araddr_o=0xBFC0_0004, arlen_o=0; rend_o in cycle 3; line_o=0x…0000_DEADBEEF with upper 224 bits zero.
- Backpressure:
  - stimulus: arready_i low for 3 cycles, one rvalid_i gap after beat 4;
  - response: araddr_o stable while arvalid_o high; rend_o in cycle 14; line contents correct.
- Error plus ignored request:
  - stimulus: beat 5 returns rresp=2'b10; req_i pulsed during DATA;
  - response: rerr_o=1 coincident with rend_o; no second AR issued.
- Reset mid-burst:
  - stimulus: rst_n low after beat 3;
  - response: immediately busy_o=0, rready_o=0, line_o=0; after release, a new request issues arvalid_o one cycle later.
- Early rlast:
  - stimulus: rlast_i on beat 2 of a cached burst;
  - response: rend_o the next cycle; words 2–7 of line_o are 0.

Source files
------------

// File: rtl/icache_axi_refill.sv
// -----------------------------------------------------------------------------
// icache_axi_refill
//
// Read-refill engine between the I-cache second stage and the AXI4 read
// channel. A one-cycle miss request starts a single AXI4 INCR burst: 8 beats of
// 32 bit for a cached line, or 1 beat for an uncached fetch. Returned beats are
// assembled into a 256-bit line. Completion is signalled by a one-cycle rend_o
// pulse. The line then stays stable until the next accepted request, so the
// stage-2 word select and the cache install can both read it.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_i             refill request (sampled only while idle)
//   addr_i            physical fetch address
//   uncached_i        1 = single-beat uncached read
//   busy_o            high whenever the engine is not idle
//   rend_o            one-cycle pulse, line_o valid
//   rerr_o            one-cycle pulse with rend_o if any beat had rresp != OKAY
//   line_o            assembled line, word k = bits [32k+31:32k]
//   ar*_o, arready_i  AXI4 read-address channel (single outstanding burst)
//   r*_i, rready_o    AXI4 read-data channel (rid_i is not checked)
// -----------------------------------------------------------------------------
module icache_axi_refill #(
    parameter logic [3:0] ARID_VAL = 4'd0
) (
    input  logic         clk,
    input  logic         rst_n,

    // Refill request side
    input  logic         req_i,
    input  logic [31:0]  addr_i,
    input  logic         uncached_i,
    output logic         busy_o,
    output logic         rend_o,
    output logic         rerr_o,
    output logic [255:0] line_o,

    // AXI4 read-address channel
    output logic [3:0]   arid_o,
    output logic [31:0]  araddr_o,
    output logic [7:0]   arlen_o,
    output logic [2:0]   arsize_o,
    output logic [1:0]   arburst_o,
    output logic         arlock_o,
    output logic [3:0]   arcache_o,
    output logic [2:0]   arprot_o,
    output logic         arvalid_o,
    input  logic         arready_i,

    // AXI4 read-data channel
    input  logic [3:0]   rid_i,
    input  logic [31:0]  rdata_i,
    input  logic [1:0]   rresp_i,
    input  logic         rlast_i,
    input  logic         rvalid_i,
    output logic         rready_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e         state_q,    state_d;
    logic [31:0]    addr_q,     addr_d;
    logic           uncached_q, uncached_d;
    logic [2:0]     cnt_q,      cnt_d;
    logic           full_q,     full_d;   // word 7 written; further beats dropped
    logic           err_q,      err_d;
    logic [255:0]   line_q,     line_d;

    // rid_i is ignored because only one burst is ever outstanding; the low
    // address bits are dropped by the alignment of both request kinds.
    logic unused_inputs;
    assign unused_inputs = ^{rid_i, addr_i[1:0]};

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: the line is an ordinary 256-bit register, not a memory array, so it
    // is cleared by reset like every other flop; a mid-burst reset must never
    // expose a half-assembled line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            uncached_q <= 1'b0;
            cnt_q      <= '0;
            full_q     <= 1'b0;
            err_q      <= 1'b0;
            line_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of every other flop, independent of statement order.
            state_q    <= state_d;
            addr_q     <= addr_d;
            uncached_q <= uncached_d;
            cnt_q      <= cnt_d;
            full_q     <= full_d;
            err_q      <= err_d;
            line_q     <= line_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through
        // the case below can leave one unassigned and infer a latch.
        state_d    = state_q;
        addr_d     = addr_q;
        uncached_d = uncached_q;
        cnt_d      = cnt_q;
        full_d     = full_q;
        err_d      = err_q;
        line_d     = line_q;

        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    // Cached lines align to 32 bytes, uncached fetches to a word.
                    addr_d     = uncached_i ? {addr_i[31:2], 2'b00}
                                            : {addr_i[31:5], 5'b00000};
                    uncached_d = uncached_i;
                    cnt_d      = '0;
                    full_d     = 1'b0;
                    err_d      = 1'b0;
                    line_d     = '0;
                    state_d    = S_ADDR;
                end
            end

            S_ADDR: begin
                // arvalid_o is high here; the handshake completes on arready_i.
                if (arready_i) begin
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                if (rvalid_i) begin
                    // A misbehaving slave that sends more than 8 beats must not
                    // clobber word 7, hence the separate full flag.
                    if (!full_q) begin
                        line_d[{cnt_q, 5'b00000} +: 32] = rdata_i;
                    end
                    err_d = err_q | (rresp_i != 2'b00);
                    if (cnt_q == 3'd7) begin
                        full_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                    // An early rlast ends the transfer; unwritten words stay 0.
                    if (rlast_i) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs: decoded from state and registered fields only, so there is no
    // combinational path from any AXI input back to arvalid_o or rready_o.
    // -------------------------------------------------------------------------
    assign busy_o    = (state_q != S_IDLE);
    assign arvalid_o = (state_q == S_ADDR);
    assign rready_o  = (state_q == S_DATA);
    assign rend_o    = (state_q == S_DONE);
    assign rerr_o    = (state_q == S_DONE) & err_q;
    assign line_o    = line_q;

    assign arid_o    = ARID_VAL;
    assign araddr_o  = addr_q;
    assign arlen_o   = uncached_q ? 8'd0 : 8'd7;
    assign arsize_o  = 3'b010;          // 4 bytes per beat
    assign arburst_o = 2'b01;           // INCR
    assign arlock_o  = 1'b0;
    assign arcache_o = 4'b0000;
    assign arprot_o  = 3'b000;

endmodule

// File: tb/tb_icache_axi_refill.sv
// -----------------------------------------------------------------------------
// tb_icache_axi_refill
//
// Self-checking bench for icache_axi_refill. A behavioural AXI slave answers
// each burst from a table of beats; the expected line, error flag and rend_o
// cycle are computed from the beat table and the stall/gap schedule with plain
// arithmetic. Inputs are driven and outputs sampled on the falling clock edge.
// Cycle numbering: the rising edge that samples req_i is edge 0; the cycle
// after it is cycle 1.
// -----------------------------------------------------------------------------
module tb_icache_axi_refill;

    localparam logic [3:0] ARID = 4'd5;
    localparam int         BUDGET = 300;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_i;
    logic [31:0]  addr_i;
    logic         uncached_i;
    logic         busy_o;
    logic         rend_o;
    logic         rerr_o;
    logic [255:0] line_o;
    logic [3:0]   arid_o;
    logic [31:0]  araddr_o;
    logic [7:0]   arlen_o;
    logic [2:0]   arsize_o;
    logic [1:0]   arburst_o;
    logic         arlock_o;
    logic [3:0]   arcache_o;
    logic [2:0]   arprot_o;
    logic         arvalid_o;
    logic         arready_i;
    logic [3:0]   rid_i;
    logic [31:0]  rdata_i;
    logic [1:0]   rresp_i;
    logic         rlast_i;
    logic         rvalid_i;
    logic         rready_o;

    int vectors     = 0;
    int miscompares = 0;

    // Beat table served by the slave model (up to 9 beats to cover overrun).
    logic [31:0] bdata [0:8];
    logic [1:0]  bresp [0:8];

    icache_axi_refill #(.ARID_VAL(ARID)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .addr_i     (addr_i),
        .uncached_i (uncached_i),
        .busy_o     (busy_o),
        .rend_o     (rend_o),
        .rerr_o     (rerr_o),
        .line_o     (line_o),
        .arid_o     (arid_o),
        .araddr_o   (araddr_o),
        .arlen_o    (arlen_o),
        .arsize_o   (arsize_o),
        .arburst_o  (arburst_o),
        .arlock_o   (arlock_o),
        .arcache_o  (arcache_o),
        .arprot_o   (arprot_o),
        .arvalid_o  (arvalid_o),
        .arready_i  (arready_i),
        .rid_i      (rid_i),
        .rdata_i    (rdata_i),
        .rresp_i    (rresp_i),
        .rlast_i    (rlast_i),
        .rvalid_i   (rvalid_i),
        .rready_o   (rready_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        req_i      = 1'b0;
        addr_i     = '0;
        uncached_i = 1'b0;
        arready_i  = 1'b0;
        rid_i      = '0;
        rdata_i    = '0;
        rresp_i    = '0;
        rlast_i    = 1'b0;
        rvalid_i   = 1'b0;
    endtask

    task automatic fill_random(input bit with_errors);
        for (int i = 0; i < 9; i++) begin
            bdata[i] = $urandom;
            bresp[i] = (with_errors && $urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        end
    endtask

    // One complete refill. Called and returns on a falling edge with the DUT idle.
    //   stall     : cycles arready_i is held low after arvalid_o rises
    //   nbeats    : beats served; rlast_i on the last one
    //   gap_after : one idle R cycle after this many beats (0 = none)
    //   pulse_req : pulse req_i once while the data phase is running
    task automatic run_txn(input logic [31:0] addr, input bit unc, input int stall,
                           input int nbeats, input int gap_after, input bit pulse_req);
        logic [31:0]  exp_addr;
        logic [255:0] exp_line;
        bit           exp_err;
        int           exp_rend;
        int           rend_cyc;
        int           sent;
        int           stall_left;
        int           ar_hs;
        bit           gap_pending;
        bit           pulsed;

        // Reference model: what the slave delivers, placed word by word.
        exp_addr = unc ? (addr & 32'hFFFF_FFFC) : (addr & 32'hFFFF_FFE0);
        exp_line = '0;
        exp_err  = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            if (i < 8) exp_line[i*32 +: 32] = bdata[i];
            if (bresp[i] != 2'b00) exp_err = 1'b1;
        end
        exp_rend = 2 + stall + nbeats + ((gap_after > 0 && gap_after < nbeats) ? 1 : 0);

        req_i      = 1'b1;
        addr_i     = addr;
        uncached_i = unc;
        @(posedge clk);
        @(negedge clk);
        // Scramble the request fields: the burst must use the latched copies.
        req_i      = 1'b0;
        addr_i     = $urandom;
        uncached_i = 1'($urandom_range(0, 1));
        check("arvalid_cycle1", arvalid_o, 1'b1);
        check("busy_cycle1", busy_o, 1'b1);
        check("line_cleared", line_o, '0);

        rend_cyc    = -1;
        sent        = 0;
        stall_left  = stall;
        ar_hs       = 0;
        gap_pending = 1'b0;
        pulsed      = 1'b0;
        for (int cyc = 1; cyc <= BUDGET; cyc++) begin
            if (rend_o) begin
                rend_cyc = cyc;
                break;
            end
            if (arvalid_o) begin
                check("araddr", araddr_o, exp_addr);
                check("arlen", arlen_o, unc ? 8'd0 : 8'd7);
            end
            req_i = 1'b0;
            if (pulse_req && rready_o && !pulsed) begin
                req_i  = 1'b1;
                addr_i = 32'h0BAD_0040;
                pulsed = 1'b1;
            end
            // AR channel
            arready_i = arvalid_o && (stall_left == 0);
            if (arvalid_o && stall_left > 0) stall_left--;
            if (arvalid_o && arready_i) ar_hs++;
            // R channel: junk on data/resp whenever no beat is offered
            rvalid_i = 1'b0;
            rlast_i  = 1'b0;
            rdata_i  = $urandom;
            rresp_i  = 2'($urandom_range(1, 3));
            if (rready_o && sent < nbeats) begin
                if (gap_pending) begin
                    gap_pending = 1'b0;
                end else begin
                    rvalid_i = 1'b1;
                    rdata_i  = bdata[sent];
                    rresp_i  = bresp[sent];
                    rlast_i  = (sent == nbeats - 1);
                    sent++;
                    if (sent == gap_after) gap_pending = 1'b1;
                end
            end
            @(negedge clk);
        end

        check("rend_cycle", rend_cyc, exp_rend);
        check("rerr", rerr_o, exp_err);
        check("line", line_o, exp_line);
        check("busy_done", busy_o, 1'b1);
        check("ar_count", ar_hs, 1);

        idle_inputs();
        @(negedge clk);
        check("rend_pulse", rend_o, 1'b0);
        check("rerr_pulse", rerr_o, 1'b0);
        check("busy_idle", busy_o, 1'b0);
        check("line_hold", line_o, exp_line);
    endtask

    // Reset asserted after the third beat of a cached burst, beat 4 still on the bus.
    task automatic reset_mid_burst();
        fill_random(1'b0);
        req_i      = 1'b1;
        addr_i     = $urandom;
        uncached_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_i     = 1'b0;
        check("rst_arvalid", arvalid_o, 1'b1);
        arready_i = 1'b1;
        @(negedge clk);
        arready_i = 1'b0;
        for (int b = 0; b < 3; b++) begin
            rvalid_i = 1'b1;
            rdata_i  = bdata[b];
            rresp_i  = 2'b00;
            rlast_i  = 1'b0;
            @(negedge clk);
        end
        check("pre_rst_rready", rready_o, 1'b1);
        rdata_i = bdata[3];
        rst_n   = 1'b0;
        #1;
        check("rst_busy", busy_o, 1'b0);
        check("rst_rready", rready_o, 1'b0);
        check("rst_line", line_o, '0);
        check("rst_arvalid_low", arvalid_o, 1'b0);
        check("rst_araddr", araddr_o, '0);
        @(negedge clk);
        check("rst_hold_rready", rready_o, 1'b0);
        rvalid_i = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check("post_rst_line", line_o, '0);
        check("post_rst_busy", busy_o, 1'b0);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bdata[i] = '0;
            bresp[i] = '0;
        end
        repeat (3) @(negedge clk);

        // Reset state and constant AR fields
        check("reset_busy", busy_o, 1'b0);
        check("reset_arvalid", arvalid_o, 1'b0);
        check("reset_rready", rready_o, 1'b0);
        check("reset_rend", rend_o, 1'b0);
        check("reset_rerr", rerr_o, 1'b0);
        check("reset_line", line_o, '0);
        check("reset_araddr", araddr_o, '0);
        check("arid", arid_o, ARID);
        check("arsize", arsize_o, 3'b010);
        check("arburst", arburst_o, 2'b01);
        check("arlock", arlock_o, 1'b0);
        check("arcache", arcache_o, 4'b0000);
        check("arprot", arprot_o, 3'b000);
        rst_n = 1'b1;
        @(negedge clk);

        // Cached refill, zero-wait slave, 0x11111111 .. 0x88888888
        for (int k = 0; k < 9; k++) begin
            bdata[k] = 32'h1111_1111 * (k + 1);
            bresp[k] = 2'b00;
        end
        run_txn(32'h1FC0_0234, 1'b0, 0, 8, 0, 1'b0);

        // Uncached fetch
        bdata[0] = 32'hDEAD_BEEF;
        run_txn(32'hBFC0_0004, 1'b1, 0, 1, 0, 1'b0);

        // Backpressure: 3 AR stall cycles, one R bubble after beat 4
        fill_random(1'b0);
        run_txn($urandom, 1'b0, 3, 8, 4, 1'b0);

        // Error on beat 5 plus a request pulsed during the data phase
        fill_random(1'b0);
        bresp[4] = 2'b10;
        run_txn($urandom, 1'b0, 0, 8, 0, 1'b1);

        // Reset mid-burst, then a fresh request must start cleanly
        reset_mid_burst();
        fill_random(1'b0);
        run_txn($urandom, 1'b0, 0, 8, 0, 1'b0);

        // Early rlast on beat 2
        fill_random(1'b0);
        run_txn($urandom, 1'b0, 0, 2, 0, 1'b0);

        // Overrun: 9 beats, word 7 must keep beat 8
        fill_random(1'b0);
        run_txn($urandom, 1'b0, 0, 9, 0, 1'b0);

        // Randomized mix
        repeat (40) begin
            bit unc;
            int nb;
            int st;
            int gp;
            unc = ($urandom_range(0, 3) == 0);
            if (unc) begin
                nb = 1;
            end else begin
                case ($urandom_range(0, 5))
                    0:       nb = $urandom_range(1, 7);
                    1:       nb = 9;
                    default: nb = 8;
                endcase
            end
            st = $urandom_range(0, 3);
            gp = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 8) : 0;
            fill_random(1'b1);
            run_txn($urandom, unc, st, nb, gp, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
